register_file_reader: RTL

REGISTER_FILE_READER -- requirements
Module: register_file_reader

---
 rtl/register_file_reader.sv | 90 +++++++++
 1 files changed

// File: rtl/register_file_reader.sv
// Two-read/one-write register file with registered, pulsed read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to readers.
module register_file_reader #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 writeEnable,
  input  logic [ADDR_BITS-1:0] writeAddr,
  input  logic [WIDTH-1:0]     writeData,
  input  logic                 readEnableA,
  input  logic [ADDR_BITS-1:0] readAddrA,
  output logic [WIDTH-1:0]     readDataA,
  output logic                 readValidA,
  input  logic                 readEnableB,
  input  logic [ADDR_BITS-1:0] readAddrB,
  output logic [WIDTH-1:0]     readDataB,
  output logic                 readValidB
);

  localparam int DEPTH = 2 ** ADDR_BITS;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic [WIDTH-1:0] regs_q [DEPTH];

  logic             wr_en;
  logic             hit_a;
  logic             hit_b;
  logic [WIDTH-1:0] data_a_d;
  logic [WIDTH-1:0] data_b_d;
  logic [WIDTH-1:0] data_a_q;
  logic [WIDTH-1:0] data_b_q;
  logic             valid_a_q;
  logic             valid_b_q;

  // Register 0 is never written, so it stays at its reset value of 0.
  assign wr_en = writeEnable && (writeAddr != '0);

  assign hit_a = wr_en && (readAddrA == writeAddr);
  assign hit_b = wr_en && (readAddrB == writeAddr);

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (readEnableA) begin
      data_a_d = (Bypass && hit_a) ? writeData
                                   : regs_q[readAddrA];
    end
    if (readEnableB) begin
      data_b_d = (Bypass && hit_b) ? writeData
                                   : regs_q[readAddrB];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[writeAddr] <= writeData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_a_q  <= '0;
      data_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      valid_a_q <= readEnableA;
      valid_b_q <= readEnableB;
    end
  end

  assign readDataA  = data_a_q;
  assign readValidA = valid_a_q;
  assign readDataB  = data_b_q;
  assign readValidB = valid_b_q;

endmodule
